// File: rtl/pipe_pkg.sv
// Shared datapath types and helpers for inter-stage pipeline buffers.
// Provides the default payload width, a 32-bit word type and pointer wrap.
package pipe_pkg;

    localparam int PIPE_WIDTH = 32;

    typedef logic [PIPE_WIDTH-1:0] pipe_word_t;

    // Advance a circular index, wrapping from depth-1 back to 0.
    // With depth == 1 the index stays at 0.
    function automatic int unsigned ptr_next(
        input int unsigned ptr,
        input int unsigned depth
    );
        if (ptr >= depth - 1)
            return 0;
        return ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline register: a DEPTH-entry FIFO with valid/ready handshake
// on both sides, synchronous flush (squash) and an occupancy count.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous squash of all stored entries
//   in_valid/in_data   upstream offer; in_ready = buffer not full
//   out_valid/out_data oldest stored entry (zero when empty)
//   out_ready          downstream consumes this cycle
//   count              stored entries, 0..DEPTH
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    // Ready/valid come only from registered count, so no
    // combinational path runs from out_ready to in_ready.
    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (flush) begin
            // Squash wins over any handshake this cycle;
            // storage is left as is, it is unreachable once empty.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr <= PW'(ptr_next(32'(r_wr_ptr), DEPTH));
            end
            if (w_pop)
                r_rd_ptr <= PW'(ptr_next(32'(r_rd_ptr), DEPTH));
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) r_count <= FULL
    );

    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n) !(w_pop && r_count == '0)
    );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer: three configurations checked
// against queue models every cycle, plus directed literal expectations.
module tb_pipe_stage_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: WIDTH=32 DEPTH=2
    logic        a_fl = 0, a_iv = 0, a_or = 0;
    logic [31:0] a_id = 0;
    logic        a_ir, a_ov;
    logic [31:0] a_od;
    logic [1:0]  a_cnt;
    // Instance B: WIDTH=32 DEPTH=3
    logic        b_fl = 0, b_iv = 0, b_or = 0;
    logic [31:0] b_id = 0;
    logic        b_ir, b_ov;
    logic [31:0] b_od;
    logic [1:0]  b_cnt;
    // Instance C: WIDTH=8 DEPTH=1
    logic        c_fl = 0, c_iv = 0, c_or = 0;
    logic [7:0]  c_id = 0;
    logic        c_ir, c_ov;
    logic [7:0]  c_od;
    logic [0:0]  c_cnt;

    pipe_stage_buffer #(.WIDTH(32), .DEPTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_fl),
        .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_ready(a_or),
        .count(a_cnt)
    );
    pipe_stage_buffer #(.WIDTH(32), .DEPTH(3)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_fl),
        .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_ready(b_or),
        .count(b_cnt)
    );
    pipe_stage_buffer #(.WIDTH(8), .DEPTH(1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_fl),
        .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_ready(c_or),
        .count(c_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one queue of stored words per instance.
    logic [31:0] qa[$], qb[$], qc[$];
    bit pu, po;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete(); qb.delete(); qc.delete();
        end else begin
            if (a_fl) qa.delete();
            else begin
                pu = a_iv && qa.size() < 2;
                po = a_or && qa.size() > 0;
                if (po) void'(qa.pop_front());
                if (pu) qa.push_back(a_id);
            end
            if (b_fl) qb.delete();
            else begin
                pu = b_iv && qb.size() < 3;
                po = b_or && qb.size() > 0;
                if (po) void'(qb.pop_front());
                if (pu) qb.push_back(b_id);
            end
            if (c_fl) qc.delete();
            else begin
                pu = c_iv && qc.size() < 1;
                po = c_or && qc.size() > 0;
                if (po) void'(qc.pop_front());
                if (pu) qc.push_back({24'h0, c_id});
            end
        end
    end

    // Compare process: every negedge, all outputs of all instances.
    always @(negedge clk) begin
        chk("a_valid", 32'(a_ov), 32'(qa.size() != 0));
        chk("a_data",  a_od, qa.size() != 0 ? qa[0] : 32'h0);
        chk("a_count", 32'(a_cnt), qa.size());
        chk("a_ready", 32'(a_ir), 32'(qa.size() < 2));
        chk("b_valid", 32'(b_ov), 32'(qb.size() != 0));
        chk("b_data",  b_od, qb.size() != 0 ? qb[0] : 32'h0);
        chk("b_count", 32'(b_cnt), qb.size());
        chk("b_ready", 32'(b_ir), 32'(qb.size() < 3));
        chk("c_valid", 32'(c_ov), 32'(qc.size() != 0));
        chk("c_data",  32'(c_od), qc.size() != 0 ? qc[0] : 32'h0);
        chk("c_count", 32'(c_cnt), qc.size());
        chk("c_ready", 32'(c_ir), 32'(qc.size() < 1));
    end

    // One clock edge; returns just after the following negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Two words in A, then asynchronous reset mid-cycle.
        a_iv = 1; a_id = 32'h1; tick();
        a_id = 32'h2; tick();
        a_iv = 0;
        chk("pre_rst_cnt", 32'(a_cnt), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(a_ov), 32'd0);
        chk("rst_data",  a_od, 32'h0);
        chk("rst_count", 32'(a_cnt), 32'd0);
        chk("rst_ready", 32'(a_ir), 32'd1);
        rst_n = 1'b1;
        tick();

        a_iv = 1; a_id = 32'hDEADBEEF; tick();
        a_iv = 0;
        chk("first_data",  a_od, 32'hDEADBEEF);
        chk("first_count", 32'(a_cnt), 32'd1);
        a_or = 1; tick(); a_or = 0;

        // Fill and stall.
        a_iv = 1; a_id = 32'h11; tick();
        a_id = 32'h22; tick();
        chk("full_count", 32'(a_cnt), 32'd2);
        chk("full_ready", 32'(a_ir), 32'd0);
        a_id = 32'h33;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data", a_od, 32'h11);
        end
        // Full with pop: only the pop happens.
        a_or = 1; tick();
        chk("fpop_count", 32'(a_cnt), 32'd1);
        chk("fpop_data",  a_od, 32'h22);
        tick();
        chk("late_push", a_od, 32'h33);
        a_iv = 0; tick(); a_or = 0;

        // Flush with simultaneous push and pop.
        a_iv = 1; a_id = 32'hA; tick();
        a_id = 32'hB; tick();
        a_id = 32'hC; a_or = 1; a_fl = 1; tick();
        a_fl = 0; a_iv = 0; a_or = 0;
        chk("fl_count", 32'(a_cnt), 32'd0);
        chk("fl_valid", 32'(a_ov), 32'd0);
        chk("fl_ready", 32'(a_ir), 32'd1);
        a_iv = 1; a_id = 32'hD; tick();
        a_iv = 0;
        chk("fl_next", a_od, 32'hD);
        a_or = 1; tick(); a_or = 0;

        // Streaming through DEPTH=3.
        b_or = 1;
        for (int i = 1; i <= 100; i++) begin
            b_iv = 1; b_id = 32'(i); tick();
            chk("stream_data", b_od, 32'(i));
        end
        b_iv = 0; tick(); b_or = 0;

        // DEPTH=1, WIDTH=8.
        c_iv = 1; c_id = 8'hFF; tick();
        chk("c_ff", 32'(c_od), 32'hFF);
        c_id = 8'h01; tick(); tick();
        chk("c_block", 32'(c_od), 32'hFF);
        c_or = 1; tick();
        chk("c_popcnt", 32'(c_cnt), 32'd0);
        tick();
        chk("c_01", 32'(c_od), 32'h01);
        c_iv = 0; tick(); c_or = 0;

        // Random traffic on all three instances.
        for (int n = 0; n < 400; n++) begin
            a_iv = 1'($urandom); a_or = 1'($urandom);
            a_id = $urandom; a_fl = ($urandom_range(0, 19) == 0);
            b_iv = 1'($urandom); b_or = 1'($urandom);
            b_id = $urandom; b_fl = ($urandom_range(0, 19) == 0);
            c_iv = 1'($urandom); c_or = 1'($urandom);
            c_id = 8'($urandom); c_fl = ($urandom_range(0, 19) == 0);
            tick();
        end
        a_iv = 0; b_iv = 0; c_iv = 0;
        a_fl = 0; b_fl = 0; c_fl = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised elastic pipeline register for inter-stage data in the CPU datapath, e.g. ALU result to MEM/WB.
- Generalises the single-word stage latch to WIDTH bits and a DEPTH-entry FIFO.
- Adds a valid/ready handshake in both directions, a synchronous flush for branch/exception squash, and an occupancy count.
- Sits between two pipeline stages; lets the upstream stage run ahead while the downstream stage stalls.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, number of storage entries (>=1, any integer; power of two not required).
- CW, $clog2(DEPTH+1), derived width of count; not overridden by users.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all stored entries.
- in_valid  in  1  upstream offers in_data.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  buffer can accept this cycle.
- out_valid  out  1  out_data holds a valid entry.
- out_data  out  WIDTH  oldest stored payload.
- out_ready  in  1  downstream consumes this cycle.
- count  out  CW  number of stored entries, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - count=0; read and write pointers = 0; all storage entries = 0.
  - Outputs: out_valid=0, out_data=0, in_ready=1.
  - Takes effect immediately; no clock edge needed.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH).
  - Depends only on registered state; no combinational path from out_ready.
  - When full, a simultaneous pop does not enable a push in the same cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid, else all-zero.
  - No combinational path from in_data to out_data.
- Latency: a word pushed into an empty buffer at edge N is presented on out_data/out_valid after edge N, i.e. one cycle.
- Ordering: strict FIFO; no reordering, duplication or drop except by flush.
- Pointers:
  - wr_ptr advances on push; rd_ptr advances on pop.
  - Each wraps from DEPTH-1 to 0.
  - For DEPTH=1 the pointers are constant 0.
- count update per edge:
  - push & !pop: +1
  - pop & !push: -1
  - push & pop: unchanged; the push writes and the pop reads different slots, legal whenever 0<count<DEPTH.
  - neither: hold.
- Stall: out_ready=0 with out_valid=1 holds out_data stable until popped.
- Upstream contract: in_data must be held while in_valid=1 & in_ready=0. The buffer does not check this.
- Flush:
  - Highest synchronous priority: on an edge with flush=1, count=0 and pointers=0.
  - Any push or pop in that cycle is discarded and has no effect.
  - Storage contents are not cleared, but out_data reads 0 because out_valid=0.
  - in_ready is 1 in the following cycle.
- Simulation checks (assertions): count never exceeds DEPTH and never underflows.
- Single clock domain; no negedge logic anywhere.

Decomposition:
- Shared package pipe_pkg: default WIDTH (32) and a pipe_word_t typedef for 32-bit datapath payloads.
- Pointer-increment-with-wrap goes in pipe_pkg as a function, shared with future multi-stage buffers.
- Storage array, pointers and count stay in one module; no sub-module required.
- Optional: pipe_buffer_mem, a WIDTH x DEPTH register file with one write and one read port, if synthesis needs it isolated.

Test Plan:
- Reset/basic: assert rst_n low mid-run with count=2 -> out_valid=0, out_data=0, count=0, in_ready=1 immediately. Release, push 0xDEADBEEF -> next cycle out_valid=1, out_data=0xDEADBEEF, count=1.
- Fill and stall (DEPTH=2): push 0x11, 0x22 with out_ready=0 -> count=2, in_ready=0. Offer 0x33 -> not accepted. out_data stays 0x11 for 5 stall cycles.
- Full with simultaneous pop (DEPTH=2): count=2, in_valid=1, out_ready=1 -> only the pop occurs; count=1, out_data=0x22; 0x33 is accepted next cycle.
- Streaming (DEPTH=3): push 1..100 every cycle with out_ready=1 -> output sequence 1..100 in order, count stays 1 in steady state, pointers wrap 2->0 with no loss.
- Flush: count=2 (0xA, 0xB); assert flush together with push 0xC and pop -> next cycle count=0, out_valid=0, in_ready=1. Then push 0xD -> first output is 0xD.
- Parameter sweep: DEPTH=1 and WIDTH=8 -> push 0xFF, push blocked while full, pop, push 0x01 -> outputs 0xFF then 0x01; count only ever 0 or 1.
